alu_seq_shifter: RTL and testbench
==================================

// Module: alu_seq_shifter
// PURPOSE
//  Multi-cycle, parametrised shift/rotate unit for the ALU datapath. It generalises the fixed right-rotate to
//  five modes (LSL, LSR, ASR, ROR, ROL) with a runtime amount and a configurable bits-per-cycle step.
//  It uses a valid/ready handshake on both sides and produces NZCV flags with the result.
//  It sits beside the adder and logic units and feeds the ALU result/flag mux.
// PARAMETERS
//  LEN   8  data width in bits (>=2)
//  AW    4  amount width; must be >= $clog2(LEN)+1
//  STEP  1  maximum bits shifted per cycle (1..LEN)
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    operand/command valid
//  in_ready   out  1    unit can accept a command (high only in IDLE)
//  a          in   LEN  operand
//  amt        in   AW   shift amount (unsigned)
//  mode       in   3    000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 ROL; 101-111 illegal
//  out_valid  out  1    result and flags valid
//  out_ready  in   1    consumer accepts the result
//  result     out  LEN  shifted/rotated value
//  n,c,z,v    out  1    negative, carry, zero and overflow flags
// BEHAVIOUR
//  - Reset: state=IDLE; result, n, c, z, v and out_valid are 0; in_ready is 1. Reset mid-operation aborts the
//    shift and discards the work; no out_valid is produced for the aborted command.
//  - States: IDLE -> (in_valid & in_ready) -> SHIFT, or -> DONE if eff==0; SHIFT -> DONE when rem==0;
//    DONE -> (out_ready) -> IDLE.
//  - Accept edge: latches a into the working register, latches mode and eff, and sets rem=eff. c, v are cleared.
//  - Effective amount (eff): ROR/ROL use amt mod LEN. LSL/LSR/ASR use min(amt, LEN). Illegal modes use eff=0.
//  - Each SHIFT cycle shifts by k=min(STEP,rem) and sets rem-=k. Cycle count = ceil(eff/STEP).
//    out_valid goes high in the cycle after the last SHIFT edge, or in the cycle after accept when eff==0.
//  - Fill bits: LSL/LSR fill with 0. ASR replicates the MSB. ROR/ROL wrap.
//  - c: the last bit moved out, updated every step.
//    LSL: bit LEN-k of the pre-step value. LSR/ASR: bit k-1. ROR: new MSB. ROL: new LSB.
//    eff==0 gives c=0. LSL/LSR with amt>LEN force c=0. ASR with amt>=LEN gives c=a[LEN-1].
//  - v: LSL only. Sticky OR over every single-bit position of MSB(before)!=MSB(after); 0 for all other modes.
//  - n=result[LEN-1] and z=(result==0); both are valid whenever out_valid is high.
//  - DONE holds result and all flags stable until out_ready is sampled high. in_ready stays 0 outside IDLE.
//    in_valid is ignored while busy; there is no queueing and no same-cycle accept on the output handshake.
// STRUCTURE
//  - Package alu_shift_pkg holds: the mode localparams (MODE_LSL..MODE_ROL), the state encoding
//    (ST_IDLE, ST_SHIFT, ST_DONE) and a function computing eff from amt, mode and LEN.
//  - Sub-module alu_shift_step is combinational. Inputs: data[LEN], k (0..STEP), mode.
//    Outputs: data_out, carry_out, v_step. The top-level holds the FSM, rem counter and flag registers.
// TESTING (LEN=8 unless stated)
//  1 ROR a=8'b11111000 amt=3 STEP=1 -> 3 SHIFT cycles; result=8'b00011111, n=0, z=0, c=0, v=0.
//  2 LSL a=8'b00110011 amt=2 -> result=8'b11001100, c=0, v=1, n=1.
//  3 ASR a=8'b10000000 amt=9, STEP=1 then STEP=4 -> 8 and 2 SHIFT cycles; result=8'hFF, c=1, n=1.
//  4 LSR a=8'b00011110 amt=5 STEP=2 -> 3 SHIFT cycles; result=0, z=1, c=1.
//  5 amt=0 (any mode) and mode=3'b111 -> out_valid in the cycle after accept; result=a, c=0, v=0.
//  6 Backpressure and reset:
//    hold out_ready=0 for 3 cycles while pulsing in_valid -> result and flags stable, in_ready=0, second command dropped;
//    assert rst during SHIFT -> all outputs 0, in_ready=1, no out_valid.

Source files
------------

// File: rtl/alu_shift_pkg.sv
// Shared definitions for the sequential shift/rotate unit: mode codes,
// FSM state encoding and the effective-amount rule.
package alu_shift_pkg;

   localparam logic [2:0] MODE_LSL = 3'b000;
   localparam logic [2:0] MODE_LSR = 3'b001;
   localparam logic [2:0] MODE_ASR = 3'b010;
   localparam logic [2:0] MODE_ROR = 3'b011;
   localparam logic [2:0] MODE_ROL = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Rotates wrap modulo the width; shifts saturate at the width, since
   // shifting further changes nothing. Illegal modes do no work at all.
   function automatic int unsigned calc_eff(input int unsigned amt,
                                            input logic [2:0]  mode,
                                            input int unsigned len);
      int unsigned eff;
      eff = 0;
      case (mode)
         MODE_ROR, MODE_ROL:           eff = amt % len;
         MODE_LSL, MODE_LSR, MODE_ASR: eff = (amt > len) ? len : amt;
         default:                      eff = 0;
      endcase
      return eff;
   endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-step shifter: moves data by k bits (0..STEP) in the
// given mode, reporting the last bit moved out and any LSL sign change.
module alu_shift_step
   import alu_shift_pkg::*;
#(
   parameter int LEN  = 8,
   parameter int STEP = 1,
   parameter int KW   = $clog2(STEP + 1)
) (
   input  logic [LEN-1:0] data,
   input  logic [KW-1:0]  k,
   input  logic [2:0]     mode,
   output logic [LEN-1:0] data_out,
   output logic           carry_out,
   output logic           v_step
);

   logic [LEN-1:0] tmp;
   logic           cy;
   logic           vs;

   // Unrolled chain of single-bit moves so carry and overflow follow each bit.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path can
      // leave it unassigned and infer a latch; blocking '=' is correct here
      // because each unrolled stage must see the previous stage's value.
      tmp = data;
      cy  = 1'b0;
      vs  = 1'b0;
      for (int j = 0; j < STEP; j++) begin
         if (j < int'(k)) begin
            case (mode)
               MODE_LSL: begin
                  cy  = tmp[LEN-1];
                  tmp = {tmp[LEN-2:0], 1'b0};
                  vs  = vs | (cy ^ tmp[LEN-1]);
               end
               MODE_LSR: begin
                  cy  = tmp[0];
                  tmp = {1'b0, tmp[LEN-1:1]};
               end
               MODE_ASR: begin
                  cy  = tmp[0];
                  tmp = {tmp[LEN-1], tmp[LEN-1:1]};
               end
               MODE_ROR: begin
                  tmp = {tmp[0], tmp[LEN-1:1]};
                  cy  = tmp[LEN-1];
               end
               MODE_ROL: begin
                  tmp = {tmp[LEN-2:0], tmp[LEN-1]};
                  cy  = tmp[0];
               end
               default: begin
                  tmp = tmp;
               end
            endcase
         end
      end
      data_out  = tmp;
      carry_out = cy;
      v_step    = vs;
   end

endmodule

// File: rtl/alu_seq_shifter.sv
// Multi-cycle shift/rotate unit with valid/ready on both sides and NZCV
// flags. Shifts up to STEP bits per cycle until the remaining amount is 0.
module alu_seq_shifter
   import alu_shift_pkg::*;
#(
   parameter int LEN  = 8,
   parameter int AW   = 4,
   parameter int STEP = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [LEN-1:0] a,
   input  logic [AW-1:0]  amt,
   input  logic [2:0]     mode,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [LEN-1:0] result,
   output logic           n,
   output logic           c,
   output logic           z,
   output logic           v
);

   localparam int KW = $clog2(STEP + 1);

   state_t         state, state_nx;
   logic [LEN-1:0] work;
   logic [LEN-1:0] step_data;
   logic           step_c;
   logic           step_v;
   logic [AW-1:0]  rem;
   logic [AW-1:0]  rem_nx;
   logic [AW-1:0]  eff;
   logic [AW-1:0]  k_full;
   logic [KW-1:0]  k;
   logic [2:0]     mode_q;
   logic           force_c0;
   logic           accept;

   assign eff    = AW'(calc_eff(32'(amt), mode, LEN));
   assign k_full = (rem > AW'(STEP)) ? AW'(STEP) : rem;
   assign k      = KW'(k_full);
   assign rem_nx = rem - k_full;

   alu_shift_step #(
      .LEN  (LEN),
      .STEP (STEP),
      .KW   (KW)
   ) u_step (
      .data      (work),
      .k         (k),
      .mode      (mode_q),
      .data_out  (step_data),
      .carry_out (step_c),
      .v_step    (step_v)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples its inputs from before the edge, independent of block order.
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept   = 1'b1;
               state_nx = (eff == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (rem_nx == '0) state_nx = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Datapath: latch the command, step the working value, publish on finish.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work     <= '0;
         rem      <= '0;
         mode_q   <= MODE_LSL;
         force_c0 <= 1'b0;
         result   <= '0;
         n        <= 1'b0;
         c        <= 1'b0;
         z        <= 1'b0;
         v        <= 1'b0;
      end else if (accept) begin
         work     <= a;
         rem      <= eff;
         mode_q   <= mode;
         // Shifting past the full width pushes out only fill zeros.
         force_c0 <= ((mode == MODE_LSL) || (mode == MODE_LSR)) && (amt > AW'(LEN));
         c        <= 1'b0;
         v        <= 1'b0;
         if (eff == '0) begin
            result <= a;
            n      <= a[LEN-1];
            z      <= (a == '0);
         end
      end else if (state == ST_SHIFT) begin
         work <= step_data;
         rem  <= rem_nx;
         c    <= force_c0 ? 1'b0 : step_c;
         v    <= v | step_v;
         if (rem_nx == '0) begin
            result <= step_data;
            n      <= step_data[LEN-1];
            z      <= (step_data == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_shifter.sv
// Self-checking bench: three instances (STEP = 1, 2, 4) driven by directed
// and random commands, compared with a whole-value arithmetic model.
module tb_alu_seq_shifter;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] iv;
   logic [2:0] ordy;
   logic [7:0] a;
   logic [3:0] amt;
   logic [2:0] mode;
   logic [2:0] ir, ov, nf, cf, zf, vf;
   logic [7:0] res [3];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] r;
      logic       c;
      logic       v;
      int         lat;
   } exp_t;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int ST = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      alu_seq_shifter #(.LEN(8), .AW(4), .STEP(ST)) dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (iv[g]),
         .in_ready  (ir[g]),
         .a         (a),
         .amt       (amt),
         .mode      (mode),
         .out_valid (ov[g]),
         .out_ready (ordy[g]),
         .result    (res[g]),
         .n         (nf[g]),
         .c         (cf[g]),
         .z         (zf[g]),
         .v         (vf[g])
      );
   end

   function automatic int step_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
   endfunction

   // Whole-value reference built directly from the shift/rotate definitions.
   function automatic exp_t model(input logic [7:0] av, input int amtv,
                                  input logic [2:0] md, input int st);
      exp_t        e;
      int          eff;
      logic [15:0] w;
      logic [8:0]  x;
      int          top;
      if (md == 3'd3 || md == 3'd4) eff = amtv % 8;
      else if (md <= 3'd2)          eff = (amtv > 8) ? 8 : amtv;
      else                          eff = 0;
      e.r = av;
      e.c = 1'b0;
      e.v = 1'b0;
      w   = '0;
      x   = '0;
      top = 0;
      case (md)
         3'd0: begin
            w   = {8'h00, av} << eff;
            e.r = w[7:0];
            if (eff > 0 && amtv <= 8) e.c = av[8-eff];
            // MSB history covers a[7] down to a[7-eff], zero past bit 0.
            x   = {av, 1'b0};
            top = int'(x >> (8 - eff));
            e.v = (top != 0) && (top != ((1 << (eff + 1)) - 1));
         end
         3'd1: begin
            e.r = av >> eff;
            if (eff > 0 && amtv <= 8) e.c = av[eff-1];
         end
         3'd2: begin
            e.r = $signed(av) >>> eff;
            if (amtv >= 8)    e.c = av[7];
            else if (eff > 0) e.c = av[eff-1];
         end
         3'd3: begin
            e.r = (av >> eff) | (av << (8 - eff));
            if (eff > 0) e.c = e.r[7];
         end
         3'd4: begin
            e.r = (av << eff) | (av >> (8 - eff));
            if (eff > 0) e.c = e.r[0];
         end
         default: e.r = av;
      endcase
      e.lat = (eff + st - 1) / st;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one command to instance d, wait for the result, check and retire it.
   task automatic run_op(input int d, input logic [7:0] av, input logic [3:0] amtv,
                         input logic [2:0] md, input string tag);
      exp_t e;
      int   lat;
      e = model(av, int'(amtv), md, step_of(d));
      @(negedge clk);
      a     = av;
      amt   = amtv;
      mode  = md;
      iv[d] = 1'b1;
      check({tag, "/in_ready"}, 32'(ir[d]), 32'd1);
      @(negedge clk);
      iv[d] = 1'b0;
      lat   = 0;
      while (ov[d] !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "/cycles"}, 32'(lat), 32'(e.lat));
      check({tag, "/result"}, 32'(res[d]), 32'(e.r));
      check({tag, "/c"}, 32'(cf[d]), 32'(e.c));
      check({tag, "/v"}, 32'(vf[d]), 32'(e.v));
      check({tag, "/n"}, 32'(nf[d]), 32'(e.r[7]));
      check({tag, "/z"}, 32'(zf[d]), 32'(e.r == 8'h00));
      ordy[d] = 1'b1;
      @(negedge clk);
      ordy[d] = 1'b0;
      check({tag, "/retired"}, 32'(ov[d]), 32'd0);
   endtask

   initial begin
      exp_t        e;
      logic [7:0]  held;
      int          d;
      rst  = 1'b1;
      iv   = '0;
      ordy = '0;
      a    = '0;
      amt  = '0;
      mode = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset%0d/in_ready", i), 32'(ir[i]), 32'd1);
         check($sformatf("reset%0d/out_valid", i), 32'(ov[i]), 32'd0);
         check($sformatf("reset%0d/result", i), 32'(res[i]), 32'd0);
         check($sformatf("reset%0d/nczv", i), {28'd0, nf[i], cf[i], zf[i], vf[i]}, 32'd0);
      end
      rst = 1'b0;

      // Directed cases.
      run_op(0, 8'b1111_1000, 4'd3, 3'b011, "ror3");
      run_op(0, 8'b0011_0011, 4'd2, 3'b000, "lsl2");
      run_op(0, 8'b1000_0000, 4'd9, 3'b010, "asr9_s1");
      run_op(2, 8'b1000_0000, 4'd9, 3'b010, "asr9_s4");
      run_op(1, 8'b0001_1110, 4'd5, 3'b001, "lsr5_s2");
      run_op(0, 8'b1010_0101, 4'd0, 3'b000, "amt0");
      run_op(1, 8'b0110_1001, 4'd5, 3'b111, "illegal");
      run_op(0, 8'b1111_1111, 4'd8, 3'b000, "lsl8");
      run_op(0, 8'b1000_0001, 4'd9, 3'b000, "lsl9");
      run_op(2, 8'b1000_0001, 4'd15, 3'b001, "lsr15");
      run_op(2, 8'b1100_0011, 4'd11, 3'b100, "rol11");
      run_op(1, 8'b0111_0000, 4'd7, 3'b010, "asr7");

      // Backpressure: result held, input ignored while the result waits.
      e = model(8'b0101_0110, 3, 3'b000, 1);
      @(negedge clk);
      a = 8'b0101_0110; amt = 4'd3; mode = 3'b000; iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (e.lat) @(negedge clk);
      check("bp/out_valid", 32'(ov[0]), 32'd1);
      held = res[0];
      check("bp/result", 32'(held), 32'(e.r));
      for (int i = 0; i < 3; i++) begin
         a = 8'hFF; amt = 4'd1; mode = 3'b001; iv[0] = 1'b1;
         @(negedge clk);
         iv[0] = 1'b0;
         check($sformatf("bp%0d/hold", i), {20'd0, res[0], nf[0], cf[0], zf[0], vf[0]},
               {20'd0, e.r, e.r[7], e.c, (e.r == 8'h00), e.v});
         check($sformatf("bp%0d/in_ready", i), 32'(ir[0]), 32'd0);
         check($sformatf("bp%0d/out_valid", i), 32'(ov[0]), 32'd1);
      end
      ordy[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b0;
      check("bp/idle_ready", 32'(ir[0]), 32'd1);
      repeat (3) @(negedge clk);
      check("bp/dropped", 32'(ov[0]), 32'd0);

      // Reset in the middle of a shift.
      @(negedge clk);
      a = 8'b1011_0110; amt = 4'd7; mode = 3'b011; iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst/outputs", {20'd0, res[0], nf[0], cf[0], zf[0], vf[0]}, 32'd0);
      check("rst/in_ready", 32'(ir[0]), 32'd1);
      check("rst/out_valid", 32'(ov[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("rst/no_valid", 32'(ov[0]), 32'd0);
      end

      // Random commands across all three step sizes, illegal modes included.
      for (int i = 0; i < 40; i++) begin
         d = int'($urandom_range(0, 2));
         run_op(d, 8'($urandom), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 5)),
                $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
